// File: rtl/machine_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : machine_run_ctrl
//  Description : CPU run controller. Sequences a CPU reset, then runs the CPU
//                freely, for a fixed burst of cycles, or halted, and counts
//                the executed CPU cycles. The counter saturates.
//                Optional breakpoint: define MACHINE_RUN_CTRL_BREAK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module machine_run_ctrl #(
  parameter int CYCLE_W    = 16,
  parameter int BURST_W    = 8,
  parameter int RST_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [BURST_W-1:0] cmd_count,
  input  logic               cpu_halt,
  output logic               cpu_ce,
  output logic               cpu_reset,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [2:0]         state,
  output logic               done
`ifdef MACHINE_RUN_CTRL_BREAK_EN
  ,
  input  logic               break_en,
  input  logic [CYCLE_W-1:0] break_cycle,
  output logic               break_hit
`endif
);

  localparam logic [7:0] c_rst_cycles = 8'(RST_CYCLES);
  localparam logic [1:0] c_op_halt    = 2'b00;
  localparam logic [1:0] c_op_run     = 2'b01;
  localparam logic [1:0] c_op_step    = 2'b10;
  localparam logic [1:0] c_op_burst   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CPURST = 3'd1,
    ST_RUN    = 3'd2,
    ST_BURST  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  state_t             r_state, w_next;
  logic [BURST_W-1:0] r_rem, w_rem;
  logic [7:0]         r_hold, w_hold;
  logic [CYCLE_W-1:0] r_cycle_count;
  logic               r_done, r_cpu_reset, r_cmd_ready;
  logic               w_done, w_clr, w_accept, w_run_like, w_break;
`ifdef MACHINE_RUN_CTRL_BREAK_EN
  logic               r_break_hit, w_bh_set, w_bh_clr;
`endif

  assign w_run_like  = (r_state == ST_RUN) || (r_state == ST_BURST);
`ifdef MACHINE_RUN_CTRL_BREAK_EN
  // Breakpoint fires before the matching cycle executes.
  assign w_break     = break_en && (r_cycle_count == break_cycle);
  assign break_hit   = r_break_hit;
`else
  assign w_break     = 1'b0;
`endif
  assign cpu_ce      = w_run_like && !cpu_halt && !w_break;
  assign w_accept    = cmd_valid && r_cmd_ready;
  assign state       = r_state;
  assign cycle_count = r_cycle_count;
  assign done        = r_done;
  assign cpu_reset   = r_cpu_reset;
  assign cmd_ready   = r_cmd_ready;

  // Next-state, burst length, reset-hold and completion decisions.
  always_comb begin
    w_next = r_state;
    w_rem  = r_rem;
    w_hold = r_hold;
    w_done = 1'b0;
    w_clr  = 1'b0;
`ifdef MACHINE_RUN_CTRL_BREAK_EN
    w_bh_set = 1'b0;
    w_bh_clr = 1'b0;
`endif
    if (start_reset) begin
      // Reset request overrides everything, including an active burst.
      w_next = ST_CPURST;
      w_hold = c_rst_cycles;
      w_rem  = '0;
      w_clr  = 1'b1;
`ifdef MACHINE_RUN_CTRL_BREAK_EN
      w_bh_clr = 1'b1;
`endif
    end else begin
      case (r_state)
        ST_CPURST: begin
          w_clr = 1'b1;
          w_rem = '0;
`ifdef MACHINE_RUN_CTRL_BREAK_EN
          w_bh_clr = 1'b1;
`endif
          if (r_hold <= 8'd1) w_next = ST_IDLE;
          else                w_hold = r_hold - 8'd1;
        end
        ST_IDLE: begin
          if (w_accept) begin
`ifdef MACHINE_RUN_CTRL_BREAK_EN
            w_bh_clr = 1'b1;
`endif
            case (cmd_op)
              c_op_run:  w_next = ST_RUN;
              c_op_step: begin
                w_next = ST_BURST;
                w_rem  = BURST_W'(1);
              end
              c_op_burst: begin
                if (cmd_count != '0) begin
                  w_next = ST_BURST;
                  w_rem  = cmd_count;
                end else begin
                  // Zero-length burst completes immediately.
                  w_done = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (cpu_halt) begin
            w_next = ST_HALTED;
            w_done = 1'b1;
          end else if (w_break) begin
            w_next = ST_IDLE;
            w_done = 1'b1;
`ifdef MACHINE_RUN_CTRL_BREAK_EN
            w_bh_set = 1'b1;
`endif
          end else if (w_accept) begin
            // Only HALT matters while running; other commands are dropped.
            if (cmd_op == c_op_halt) w_next = ST_IDLE;
          end
        end
        ST_BURST: begin
          if (cpu_halt) begin
            w_next = ST_HALTED;
            w_done = 1'b1;
            w_rem  = '0;
          end else if (w_break) begin
            w_next = ST_IDLE;
            w_done = 1'b1;
            w_rem  = '0;
`ifdef MACHINE_RUN_CTRL_BREAK_EN
            w_bh_set = 1'b1;
`endif
          end else if (r_rem <= BURST_W'(1)) begin
            w_next = ST_IDLE;
            w_done = 1'b1;
            w_rem  = '0;
          end else begin
            w_rem = r_rem - BURST_W'(1);
          end
        end
        ST_HALTED: ;
        default: begin
          // Illegal encodings recover through a full CPU reset.
          w_next = ST_CPURST;
          w_hold = c_rst_cycles;
          w_rem  = '0;
          w_clr  = 1'b1;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_CPURST;
      r_rem         <= '0;
      r_hold        <= c_rst_cycles;
      r_cycle_count <= '0;
      r_done        <= 1'b0;
      r_cpu_reset   <= 1'b1;
      r_cmd_ready   <= 1'b0;
`ifdef MACHINE_RUN_CTRL_BREAK_EN
      r_break_hit   <= 1'b0;
`endif
    end else begin
      r_state     <= w_next;
      r_rem       <= w_rem;
      r_hold      <= w_hold;
      r_done      <= w_done;
      r_cpu_reset <= (w_next == ST_CPURST);
      r_cmd_ready <= (w_next == ST_IDLE) || (w_next == ST_RUN);
      if (w_clr)
        r_cycle_count <= '0;
      else if (cpu_ce && (r_cycle_count != {CYCLE_W{1'b1}}))
        r_cycle_count <= r_cycle_count + CYCLE_W'(1);
`ifdef MACHINE_RUN_CTRL_BREAK_EN
      if (w_bh_set)      r_break_hit <= 1'b1;
      else if (w_bh_clr) r_break_hit <= 1'b0;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_machine_run_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_machine_run_ctrl
//  Description : Self-checking bench for machine_run_ctrl (default build and
//                MACHINE_RUN_CTRL_BREAK_EN build). A second instance with a
//                4-bit cycle counter shares the stimulus to show saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_machine_run_ctrl;

  localparam int RST = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_count = 8'd0;
  logic       cpu_halt = 1'b0;

  logic        cmd_ready, cpu_ce, cpu_reset, done;
  logic [15:0] cycle_count;
  logic [2:0]  state;
  logic        s_cmd_ready, s_cpu_ce, s_cpu_reset, s_done;
  logic [3:0]  s_cycle_count;
  logic [2:0]  s_state;
`ifdef MACHINE_RUN_CTRL_BREAK_EN
  logic        break_en = 1'b0;
  logic [15:0] break_cycle = 16'd0;
  logic        break_hit, s_break_hit;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int t_ce, t_done, t_rst;

  // Reference model: plain integers, updated once per clock edge.
  int m_st = 1, m_rem = 0, m_hold = RST, m_cnt = 0;
  bit m_done = 1'b0, m_bh = 1'b0;
  bit m_ce, m_brk, m_acc;

  machine_run_ctrl #(.CYCLE_W(16), .BURST_W(8), .RST_CYCLES(RST)) dut (
    .clk(clk), .reset(reset), .start_reset(start_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_count(cmd_count), .cpu_halt(cpu_halt), .cpu_ce(cpu_ce),
    .cpu_reset(cpu_reset), .cycle_count(cycle_count), .state(state),
    .done(done)
`ifdef MACHINE_RUN_CTRL_BREAK_EN
    , .break_en(break_en), .break_cycle(break_cycle), .break_hit(break_hit)
`endif
  );

  machine_run_ctrl #(.CYCLE_W(4), .BURST_W(8), .RST_CYCLES(RST)) dut_sat (
    .clk(clk), .reset(reset), .start_reset(start_reset),
    .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(cmd_op),
    .cmd_count(cmd_count), .cpu_halt(cpu_halt), .cpu_ce(s_cpu_ce),
    .cpu_reset(s_cpu_reset), .cycle_count(s_cycle_count), .state(s_state),
    .done(s_done)
`ifdef MACHINE_RUN_CTRL_BREAK_EN
    , .break_en(break_en), .break_cycle(break_cycle[3:0]), .break_hit(s_break_hit)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit exp_brk();
`ifdef MACHINE_RUN_CTRL_BREAK_EN
    return break_en && (m_st == 2 || m_st == 3) && (m_cnt == int'(break_cycle));
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_ce();
    return (m_st == 2 || m_st == 3) && !cpu_halt && !exp_brk();
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_st = 1; m_rem = 0; m_hold = RST; m_cnt = 0; m_done = 1'b0; m_bh = 1'b0;
    end else begin
      m_ce   = exp_ce();
      m_brk  = exp_brk();
      m_acc  = cmd_valid && (m_st == 0 || m_st == 2);
      m_done = 1'b0;
      if (start_reset) begin
        m_st = 1; m_hold = RST; m_rem = 0; m_cnt = 0; m_bh = 1'b0;
      end else begin
        if (m_ce) m_cnt++;
        case (m_st)
          1: begin
            m_cnt = 0; m_bh = 1'b0;
            if (m_hold == 1) m_st = 0; else m_hold--;
          end
          0: if (m_acc) begin
            m_bh = 1'b0;
            if (cmd_op == 2'd1) m_st = 2;
            else if (cmd_op == 2'd2) begin m_st = 3; m_rem = 1; end
            else if (cmd_op == 2'd3) begin
              if (cmd_count == 8'd0) m_done = 1'b1;
              else begin m_st = 3; m_rem = int'(cmd_count); end
            end
          end
          2: begin
            if (cpu_halt) begin m_st = 4; m_done = 1'b1; end
            else if (m_brk) begin m_st = 0; m_done = 1'b1; m_bh = 1'b1; end
            else if (m_acc && cmd_op == 2'd0) m_st = 0;
          end
          3: begin
            if (cpu_halt) begin m_st = 4; m_done = 1'b1; m_rem = 0; end
            else if (m_brk) begin m_st = 0; m_done = 1'b1; m_bh = 1'b1; m_rem = 0; end
            else begin
              m_rem--;
              if (m_rem == 0) begin m_st = 0; m_done = 1'b1; end
            end
          end
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("state", 32'(state), 32'(m_st));
    check("cmd_ready", 32'(cmd_ready), 32'(m_st == 0 || m_st == 2));
    check("cpu_reset", 32'(cpu_reset), 32'(m_st == 1));
    check("cpu_ce", 32'(cpu_ce), 32'(exp_ce()));
    check("done", 32'(done), 32'(m_done));
    check("cycle_count", 32'(cycle_count), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
    check("sat_cycle_count", 32'(s_cycle_count), (m_cnt > 15) ? 32'd15 : 32'(m_cnt));
`ifdef MACHINE_RUN_CTRL_BREAK_EN
    check("break_hit", 32'(break_hit), 32'(m_bh));
`endif
  endtask

  // One clock: compare at the falling edge, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    if (cpu_ce)    t_ce++;
    if (done)      t_done++;
    if (cpu_reset) t_rst++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] cnt);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    t_ce = 0; t_done = 0; t_rst = 0;
    repeat (3) step();
    reset = 1'b1;
    t_rst = 0;
    repeat (4) step();
    check("rst_hold_cycles", 32'(t_rst), 32'd3);
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_count", 32'(cycle_count), 32'd0);

    // BURST of 5
    t_ce = 0; t_done = 0;
    send(2'd3, 8'd5);
    repeat (8) step();
    check("burst5_ce_cycles", 32'(t_ce), 32'd5);
    check("burst5_done_pulses", 32'(t_done), 32'd1);
    check("burst5_count", 32'(cycle_count), 32'd5);
    check("burst5_state", 32'(state), 32'd0);

    // RUN for 10 cycles, then HALT
    t_done = 0;
    send(2'd1, 8'd0);
    repeat (9) step();
    send(2'd0, 8'd0);
    step();
    check("run10_count", 32'(cycle_count), 32'd15);
    check("run10_state", 32'(state), 32'd0);
    check("run10_no_done", 32'(t_done), 32'd0);

    // cpu_halt during RUN
    send(2'd1, 8'd0);
    step(); step();
    cpu_halt = 1'b1;
    #1;
    check("halt_ce_same_cycle", 32'(cpu_ce), 32'd0);
    step();
    check("halt_state", 32'(state), 32'd4);
    check("halt_done", 32'(done), 32'd1);
    check("halt_ready", 32'(cmd_ready), 32'd0);
    check("halt_count", 32'(cycle_count), 32'd17);
    cpu_halt = 1'b0;
    send(2'd1, 8'd0);
    check("halted_ignores_cmd", 32'(state), 32'd4);

    // start_reset out of HALTED
    start_reset = 1'b1;
    step();
    start_reset = 1'b0;
    check("sr_state", 32'(state), 32'd1);
    check("sr_count", 32'(cycle_count), 32'd0);
    repeat (3) step();
    check("sr_back_idle", 32'(state), 32'd0);

    // zero-length BURST, HALT in IDLE, STEP
    t_done = 0;
    send(2'd3, 8'd0);
    check("zero_burst_done", 32'(done), 32'd1);
    check("zero_burst_state", 32'(state), 32'd0);
    step();
    t_done = 0;
    send(2'd0, 8'd0);
    step();
    check("idle_halt_no_done", 32'(t_done), 32'd0);
    t_ce = 0; t_done = 0;
    send(2'd2, 8'd9);
    repeat (3) step();
    check("step_ce_cycles", 32'(t_ce), 32'd1);
    check("step_count", 32'(cycle_count), 32'd1);
    check("step_done", 32'(t_done), 32'd1);

    // commands discarded while running
    send(2'd1, 8'd0);
    send(2'd3, 8'd3);
    check("run_discard_burst", 32'(state), 32'd2);
    send(2'd2, 8'd0);
    check("run_discard_step", 32'(state), 32'd2);
    send(2'd0, 8'd0);
    check("run_discard_state", 32'(state), 32'd0);
    check("run_discard_count", 32'(cycle_count), 32'd4);

    // commands offered during a burst are not taken
    send(2'd3, 8'd4);
    cmd_valid = 1'b1; cmd_op = 2'd1;
    step(); step();
    cmd_valid = 1'b0;
    repeat (4) step();

    // start_reset with 3 burst cycles remaining
    send(2'd3, 8'd6);
    step(); step(); step();
    start_reset = 1'b1;
    t_done = 0;
    step();
    start_reset = 1'b0;
    check("sr_burst_state", 32'(state), 32'd1);
    check("sr_burst_count", 32'(cycle_count), 32'd0);
    repeat (4) step();
    check("sr_burst_no_done", 32'(t_done), 32'd0);

    // saturation on the 4-bit instance
    send(2'd1, 8'd0);
    repeat (19) step();
    send(2'd0, 8'd0);
    check("sat_count_4bit", 32'(s_cycle_count), 32'd15);
    check("sat_count_16bit", 32'(cycle_count), 32'd20);

    // block reset mid-burst
    send(2'd3, 8'd6);
    step(); step();
    reset = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd1);
    check("arst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("arst_count", 32'(cycle_count), 32'd0);
    check("arst_ready", 32'(cmd_ready), 32'd0);
    step(); step();
    reset = 1'b1;
    t_done = 0;
    repeat (6) step();
    check("arst_no_done", 32'(t_done), 32'd0);
    check("arst_idle", 32'(state), 32'd0);

`ifdef MACHINE_RUN_CTRL_BREAK_EN
    // breakpoint at cycle 7
    break_cycle = 16'd7; break_en = 1'b1;
    t_ce = 0; t_done = 0;
    send(2'd1, 8'd0);
    repeat (10) step();
    check("brk_ce_cycles", 32'(t_ce), 32'd7);
    check("brk_state", 32'(state), 32'd0);
    check("brk_hit", 32'(break_hit), 32'd1);
    check("brk_done", 32'(t_done), 32'd1);
    check("brk_count", 32'(cycle_count), 32'd7);
    break_en = 1'b0;
    send(2'd2, 8'd0);
    check("brk_step_clears", 32'(break_hit), 32'd0);
    repeat (3) step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/machine_run_ctrl.md
MACHINE_RUN_CTRL -- requirements
Module: machine_run_ctrl

Interface
REQ-001 Parameter SHALL be CYCLE_W, default 16, width of the executed-cycle counter.
REQ-002 Parameter SHALL be BURST_W, default 8, width of the burst length field.
REQ-003 Parameter SHALL be RST_CYCLES, default 3, number of clocks cpu_reset is held (range 1..255).
REQ-004 Port SHALL be clk  in  1  single clock; all state on rising edge.
REQ-005 Port SHALL be reset  in  1  asynchronous, active-low block reset.
REQ-006 Port SHALL be start_reset  in  1  request a CPU reset sequence.
REQ-007 Port SHALL be cmd_valid  in  1  command offered.
REQ-008 Port SHALL be cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at clk edge.
REQ-009 Port SHALL be cmd_op  in  2  00 HALT, 01 RUN, 10 STEP, 11 BURST.
REQ-010 Port SHALL be cmd_count  in  BURST_W  BURST length in CPU cycles.
REQ-011 Port SHALL be cpu_halt  in  1  CPU HLT indication.
REQ-012 Port SHALL be cpu_ce  out  1  CPU clock enable.
REQ-013 Port SHALL be cpu_reset  out  1  active-high CPU reset.
REQ-014 Port SHALL be cycle_count  out  CYCLE_W  CPU cycles executed since last CPU reset.
REQ-015 Port SHALL be state  out  3  current state encoding.
REQ-016 Port SHALL be done  out  1  one-cycle completion pulse.

Function
REQ-017 States SHALL be IDLE=0, CPURST=1, RUN=2, BURST=3, HALTED=4; other codes unreachable, recover to CPURST.
REQ-018 CPURST: cpu_reset=1, cpu_ce=0, cmd_ready=0 for exactly RST_CYCLES clocks, cycle_count cleared, then IDLE.
REQ-019 IDLE: cmd_ready=1; RUN -> RUN; STEP -> BURST with remaining=1; BURST with cmd_count>0 -> BURST with remaining=cmd_count; BURST with cmd_count=0 or HALT -> stay IDLE, done pulse only for zero BURST.
REQ-020 Latency: command accepted at edge k SHALL give first cpu_ce=1 in cycle after edge k.
REQ-021 RUN: cmd_ready=1; HALT -> IDLE at next edge; RUN/STEP/BURST accepted and discarded.
REQ-022 BURST: cmd_ready=0; cpu_ce=1 for exactly remaining cycles, then IDLE with done pulse on the edge leaving.
REQ-023 cpu_ce SHALL be (state RUN or BURST) AND NOT cpu_halt, combinationally.
REQ-024 cpu_halt=1 in RUN or BURST -> HALTED next edge, done pulse; HALTED: cmd_ready=0, exits only via start_reset.
REQ-025 start_reset SHALL have priority over all commands and states: next edge enters CPURST, counter reloaded, burst aborted, no done pulse.
REQ-026 cycle_count SHALL increment by 1 on each edge where cpu_ce=1 and SHALL saturate at all-ones (no wrap).
REQ-027 done SHALL be 0 except the single cycle following a completion event.

Reset
REQ-028 reset=0 SHALL immediately force state=CPURST, cpu_reset=1, cpu_ce=0, cmd_ready=0, done=0, cycle_count=0, remaining=0, reset-hold counter=RST_CYCLES.
REQ-029 Release of reset SHALL start the REQ-018 sequence; reset asserted mid-burst SHALL abort it with no done pulse.

Configuration
REQ-030 Macro MACHINE_RUN_CTRL_BREAK_EN defined SHALL add ports break_en in 1, break_cycle in CYCLE_W, break_hit out 1.
REQ-031 With macro: in RUN or BURST, if break_en and cycle_count==break_cycle, cpu_ce SHALL be 0 that cycle, next edge -> IDLE, done pulse, break_hit=1 until next accepted command or CPU reset.
REQ-032 Without macro: ports absent, no breakpoint logic, behaviour per REQ-017..027 only.

Verification
REQ-033 Release reset, RST_CYCLES=3 -> cpu_reset high exactly 3 clocks, then state=0, cmd_ready=1, cycle_count=0.
REQ-034 IDLE, BURST cmd_count=5 -> cpu_ce high exactly 5 cycles, cycle_count=5, done one pulse, state=0.
REQ-035 RUN 10 cycles then HALT -> cycle_count=10 or 11 per accept edge, state=0, no done; cpu_halt during RUN -> cpu_ce low same cycle, state=4, done pulse.
REQ-036 start_reset during BURST remaining=3 -> state=1 next edge, no done, cycle_count=0; CYCLE_W=4 RUN 20 cycles -> cycle_count=15 held.
REQ-037 Macro defined, break_cycle=7, break_en=1, RUN -> cpu_ce 7 cycles, state=0, break_hit=1, done pulse; STEP clears break_hit.
